// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: fetch PC generation, single-outstanding imem req/ack
// handshake, prefetch queue feeding IR. Define IFU_PERF_CNT_EN to add fetch/stall counters.
module instruction_fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd1
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   output logic [15:0] ir,
   output logic [15:0] ir_pc,
   output logic        ir_valid,
   input  logic        advance,
   input  logic        redirect,
   input  logic [15:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [15:0] fetch_count,
   output logic [15:0] stall_count
`endif
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [15:0]   fetch_pc_q, fetch_pc_d;
   logic [15:0]   redir_pc_q, redir_pc_d;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_after;
   logic          push, pop;
   logic [15:0]   data_mem [DEPTH];
   logic [15:0]   pc_mem   [DEPTH];

   // Redirect outranks both queue operations: the queue is about to be cleared anyway.
   assign push        = (state_q == FETCH) && imem_ack && !redirect;
   assign pop         = advance && ir_valid && !redirect;
   assign count_after = count_q + CW'(push) - CW'(pop);

   assign imem_req  = (state_q != IDLE);
   assign imem_addr = fetch_pc_q;
   assign ir_valid  = (count_q != '0);
   assign ir        = ir_valid ? data_mem[rd_ptr_q] : 16'h0000;
   assign ir_pc     = ir_valid ? pc_mem[rd_ptr_q]   : 16'h0000;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      redir_pc_d = redir_pc_q;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc;
               state_d    = FETCH;
            end else if (count_q < FULL) begin
               state_d = FETCH;
            end
         end
         FETCH, DRAIN: begin
            if (redirect) begin
               if (imem_ack) begin
                  fetch_pc_d = redirect_pc;
                  state_d    = FETCH;
               end else begin
                  redir_pc_d = redirect_pc;
                  state_d    = DRAIN;
               end
            end else if (imem_ack) begin
               if (state_q == DRAIN) begin
                  fetch_pc_d = redir_pc_q;
                  state_d    = FETCH;
               end else begin
                  fetch_pc_d = fetch_pc_q + PC_STEP;
                  state_d    = (count_after < FULL) ? FETCH : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         redir_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         redir_pc_q <= redir_pc_d;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_after;
         end
      end
   end

   // NOTE: queue storage is not reset; count_q gates everything visible on ir/ir_pc.
   always_ff @(posedge clock) begin
      if (push) begin
         data_mem[wr_ptr_q] <= imem_data;
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, stall_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (push && (fetch_cnt_q != 16'hFFFF))
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (imem_req && !imem_ack && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   // Counters absent: no extra state or ports.
`endif

endmodule
